// File: rtl/piso_pkg.sv
// Shared defaults for the parallel-in serial-out shifter.
package piso_pkg;
  localparam int unsigned DEF_WIDTH     = 4;
  localparam bit          DEF_MSB_FIRST = 1'b1;
endpackage

// File: rtl/piso.sv
// Parallel-in, serial-out shift register; a load edge puts the first bit on dout
// immediately, each later edge shifts one bit out with zero fill.
module piso
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic [WIDTH-1:0] din,
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  output logic             dout
);

  logic [WIDTH-1:0] r_sr;

  // Priority: reset > load > shift. Reload mid-word simply overwrites the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr <= '0;
    end else if (load) begin
      r_sr <= din;
    end else if (MSB_FIRST) begin
      r_sr <= {r_sr[WIDTH-2:0], 1'b0};
    end else begin
      r_sr <= {1'b0, r_sr[WIDTH-1:1]};
    end
  end

  // Output is a register bit only, so no input reaches dout combinationally.
  assign dout = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];

endmodule

// File: tb/tb_piso.sv
// Bench for piso: an MSB-first and an LSB-first instance driven from shared inputs,
// checked against a word/bit-index model plus hand-computed directed sequences.
module tb_piso;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic         dout_m;
  logic         dout_l;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  piso #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .din(din), .clk(clk), .reset(reset), .load(load), .dout(dout_m)
  );
  piso #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .din(din), .clk(clk), .reset(reset), .load(load), .dout(dout_l)
  );

  // clock
  always #5 clk = ~clk;

  // model: last loaded word and number of edges since its load
  logic [W-1:0] m_word  = '0;
  int           m_idx   = 0;
  bit           m_valid = 1'b0;
  logic [1:0]   exp_q[$];

  function automatic logic [1:0] model_bits();
    logic [1:0] b;
    b = 2'b00;
    if (m_valid && m_idx < W) begin
      b[1] = m_word[W-1-m_idx];
      b[0] = m_word[m_idx];
    end
    return b;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0;
    end else if (load) begin
      m_word  = din;
      m_idx   = 0;
      m_valid = 1'b1;
    end else begin
      m_idx++;
    end
    exp_q.delete();
    exp_q.push_back(model_bits());
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    logic [1:0] e;
    if (chk_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if ({dout_m, dout_l} !== e) begin
          errors++;
          $display("FAIL model_cmp t=%0t got msb/lsb=%b%b want %b%b",
                   $time, dout_m, dout_l, e[1], e[0]);
        end
      end
    end
  end

  // drive one cycle, then check one output against a literal
  task automatic tick(input logic l, input logic [W-1:0] d, input logic e,
                      input bit use_lsb, input string nm);
    logic got;
    @(negedge clk); #1;
    load = l;
    din  = d;
    @(posedge clk); #2;
    got = use_lsb ? dout_l : dout_m;
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, got, e);
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if (dout_m !== 1'b0 || dout_l !== 1'b0) begin
      errors++;
      $display("FAIL %s t=%0t got msb/lsb=%b%b want 00", nm, $time, dout_m, dout_l);
    end
  endtask

  initial begin
    logic         l;
    logic [W-1:0] d;

    // 1: async reset, then idle
    #1 reset = 1'b1;
    #1 check_zero("reset_assert");
    chk_en = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b0, 4'b0000, 1'b0, 1'b0, "idle_after_reset");

    // 2: basic word
    tick(1'b1, 4'b1010, 1'b1, 1'b0, "w1010_b0");
    tick(1'b0, 4'b0000, 1'b0, 1'b0, "w1010_b1");
    tick(1'b0, 4'b1111, 1'b1, 1'b0, "w1010_b2");
    tick(1'b0, 4'b0000, 1'b0, 1'b0, "w1010_b3");
    tick(1'b0, 4'b1111, 1'b0, 1'b0, "w1010_tail0");
    tick(1'b0, 4'b0000, 1'b0, 1'b0, "w1010_tail1");

    // 3: reload mid-word truncates
    tick(1'b1, 4'b1010, 1'b1, 1'b0, "reload_old0");
    tick(1'b0, 4'b1010, 1'b0, 1'b0, "reload_old1");
    tick(1'b1, 4'b0111, 1'b0, 1'b0, "reload_new0");
    tick(1'b0, 4'b0000, 1'b1, 1'b0, "reload_new1");
    tick(1'b0, 4'b0000, 1'b1, 1'b0, "reload_new2");
    tick(1'b0, 4'b0000, 1'b1, 1'b0, "reload_new3");
    tick(1'b0, 4'b0000, 1'b0, 1'b0, "reload_tail");

    // 4: load held high
    for (int i = 0; i < 3; i++) tick(1'b1, 4'b1000, 1'b1, 1'b0, "load_held");
    for (int i = 0; i < 3; i++) tick(1'b0, 4'b1000, 1'b0, 1'b0, "load_dropped");

    // 5: reset mid-word
    tick(1'b1, 4'b1111, 1'b1, 1'b0, "rst_word_b0");
    tick(1'b0, 4'b0000, 1'b1, 1'b0, "rst_word_b1");
    tick(1'b0, 4'b0000, 1'b1, 1'b0, "rst_word_b2");
    #1 reset = 1'b1;
    #1 check_zero("reset_midword");
    @(negedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 4'b1111, 1'b0, 1'b0, "after_reset_idle");

    // 6: LSB-first instance
    tick(1'b1, 4'b0011, 1'b1, 1'b1, "lsb_b0");
    tick(1'b0, 4'b0000, 1'b1, 1'b1, "lsb_b1");
    tick(1'b0, 4'b0000, 1'b0, 1'b1, "lsb_b2");
    tick(1'b0, 4'b0000, 1'b0, 1'b1, "lsb_b3");
    tick(1'b0, 4'b0000, 1'b0, 1'b1, "lsb_tail");

    // random traffic with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      l = ($urandom_range(0, 3) == 0);
      d = W'($urandom_range(0, (1 << W) - 1));
      @(negedge clk); #1;
      load  = l;
      din   = d;
      reset = 1'b0;
      @(posedge clk);
      if ($urandom_range(0, 39) == 0) begin
        #3 reset = 1'b1;
        #1 check_zero("rand_reset");
      end
    end
    @(negedge clk); #1;
    reset = 1'b0;
    load  = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
